// File: rtl/serial_subtractor_if.sv
// Handshake and data bus for the bit-serial subtractor.
//   start/A/B/Bin : request and operands (driven by the master)
//   ready/done    : idle indication and one-cycle completion pulse
//   diff/Bout/ovf : result, borrow out of the MSB, signed overflow
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             ready;
  logic [WIDTH-1:0] diff;
  logic             Bout;
  logic             ovf;
  logic             done;

  modport master (
    output start, A, B, Bin,
    input  ready, diff, Bout, ovf, done
  );

  modport slave (
    input  start, A, B, Bin,
    output ready, diff, Bout, ovf, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = A - B - Bin, one bit per clock,
// LSB first, through a single borrow flip-flop.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : serial_subtractor_if slave (start/A/B/Bin in; ready/diff/Bout/ovf/done out)
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic               w_last;

  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [WIDTH-1:0]   r_part;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_a_msb;
  logic               r_b_msb;

  logic               r_ready;
  logic               r_done;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
  logic               r_ovf;

  logic               w_a;
  logic               w_b;
  logic               w_d;
  logic               w_br_next;
  logic [WIDTH-1:0]   w_part_next;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    w_a         = r_op_a[0];
    w_b         = r_op_b[0];
    w_d         = w_a ^ w_b ^ r_borrow;
    w_br_next   = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
    w_part_next = {w_d, r_part[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Handshake outputs registered from the next state so they track the FSM exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_state_next == IDLE);
      r_done  <= (w_state_next == DONE);
    end
  end

  // Operand shift registers, borrow, counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_part   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_op_a   <= bus.A;
      r_op_b   <= bus.B;
      r_borrow <= bus.Bin;
      r_cnt    <= '0;
      r_a_msb  <= bus.A[WIDTH-1];
      r_b_msb  <= bus.B[WIDTH-1];
    end else if (r_state == RUN) begin
      r_op_a   <= {1'b0, r_op_a[WIDTH-1:1]};
      r_op_b   <= {1'b0, r_op_b[WIDTH-1:1]};
      r_part   <= w_part_next;
      r_borrow <= w_br_next;
      // Counter holds at the last bit rather than wrapping
      if (!w_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Final bit: publish the completed result, never a partial one
      if (w_last) begin
        r_diff <= w_part_next;
        r_bout <= w_br_next;
        r_ovf  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
      end
    end
  end

  assign bus.ready = r_ready;
  assign bus.done  = r_done;
  assign bus.diff  = r_diff;
  assign bus.Bout  = r_bout;
  assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation: start accepted at edge 0, expect done after edge WIDTH
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [7:0] exp_diff,
                       input logic exp_bout, input logic exp_ovf);
    int n;
    int ready_hi;
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bin;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    bus.Bin   = ~bin;
    check({tag, "_ready_low"}, 32'(bus.ready), 32'd0);
    n        = 0;
    ready_hi = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
      if (bus.ready !== 1'b0) ready_hi++;
    end
    check({tag, "_latency"}, 32'(n), 32'(WIDTH));
    check({tag, "_ready_busy"}, 32'(ready_hi), 32'd0);
    check({tag, "_diff"}, 32'(bus.diff), 32'(exp_diff));
    check({tag, "_bout"}, 32'(bus.Bout), 32'(exp_bout));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    tick();
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int dcount;
    logic [7:0] seen_diff;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_bout", 32'(bus.Bout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);

    // Reset wins over a simultaneous start
    bus.A     = 8'h50;
    bus.B     = 8'h20;
    bus.start = 1'b1;
    tick();
    check("rst_start_ready", 32'(bus.ready), 32'd1);
    rst       = 1'b0;
    bus.start = 1'b0;
    tick();
    check("rst_start_idle", 32'(bus.ready), 32'd1);

    do_op("basic",    8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    do_op("under",    8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    tick();
    tick();
    check("hold_diff", 32'(bus.diff), 32'hFF);
    check("hold_bout", 32'(bus.Bout), 32'd1);
    do_op("sovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    do_op("sovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    do_op("bin1",     8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
    do_op("bin0",     8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0);

    // Busy protection: second start during RUN is ignored
    bus.A     = 8'h05;
    bus.B     = 8'h03;
    bus.Bin   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.A     = 8'hAA;
    bus.B     = 8'h11;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    dcount    = 0;
    seen_diff = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        dcount++;
        seen_diff = bus.diff;
      end
    end
    check("busy_done_count", 32'(dcount), 32'd1);
    check("busy_diff", 32'(seen_diff), 32'h02);
    check("busy_ready", 32'(bus.ready), 32'd1);

    // Reset mid-operation aborts without a done pulse
    bus.A     = 8'h50;
    bus.B     = 8'h20;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_diff", 32'(bus.diff), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done !== 1'b0) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    do_op("after_abort", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor: computes diff = A - B - Bin one bit per clock, LSB first, through a single borrow flip-flop.
- Counterpart to the combinational ripple-carry adder. Trades latency for area: one full-subtractor cell instead of WIDTH cells.
- Used wherever a datapath needs subtraction or compare and can tolerate multi-cycle latency.
- Controlled by a start/ready/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal values 2 and above).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in a cycle where ready=1.
- A  input  WIDTH  minuend; sampled on the accepting edge.
- B  input  WIDTH  subtrahend; sampled on the accepting edge.
- Bin  input  1  borrow-in; sampled on the accepting edge.
- ready  output  1  high only in IDLE.
- diff  output  WIDTH  result register; holds the last completed result.
- Bout  output  1  borrow out of the MSB; 1 when unsigned A < B + Bin.
- ovf  output  1  two's-complement signed overflow of the last result.
- done  output  1  one-cycle pulse when diff, Bout and ovf are updated.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, ready=1, done=0, diff=0, Bout=0, ovf=0. Internal shift registers, borrow flip-flop and bit counter are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On start=1: latch A and B into operand shift registers, borrow<=Bin, cnt<=0, go to RUN.
  - On start=0: remain in IDLE.
- RUN:
  - ready=0.
  - Each cycle, take a=opA[0], b=opB[0], br=borrow.
  - Compute d = a^b^br and br_next = (~a&b) | (~(a^b)&br).
  - Shift d into the MSB of the partial-result register (right shift), so the LSB result lands in bit 0 after WIDTH shifts.
  - Right-shift the operand registers; borrow<=br_next; cnt<=cnt+1.
  - When cnt==WIDTH-1, go to DONE.
- RUN count width: cnt is clog2(WIDTH) bits. There is no wrap beyond WIDTH-1.
- DONE:
  - ready=0; done=1 for exactly this one cycle.
  - On entry to DONE (the same edge that leaves RUN), update the outputs: diff<=partial result; Bout<=final borrow; ovf<=(A_msb != B_msb) && (result_msb != A_msb), using the latched A/B MSBs.
  - Next cycle go to IDLE unconditionally.
- Latency: start accepted at edge 0 gives done high in the cycle after edge WIDTH. Result valid from that cycle onward.
- Throughput: a new start can be accepted every WIDTH+2 cycles.
- start while ready=0 (RUN or DONE): ignored; no queuing. A, B and Bin changing during RUN have no effect.
- diff, Bout and ovf hold their value until the next DONE. They are never driven with partial results.
- Reset asserted mid-RUN or in DONE: aborts the operation. The next state is IDLE with all reset values; done is not pulsed and diff is cleared.
- rst and start high together: reset wins.
- Arithmetic: modulo 2^WIDTH. Bin=1 subtracts one extra, for chaining multi-word subtracts.

Test Plan:
- Basic subtract: A=0x50, B=0x20, Bin=0, start pulse at edge 0 -> ready low at edges 1..9, done high one cycle after edge 8; diff=0x30, Bout=0, ovf=0; ready=1 after DONE.
- Unsigned underflow: A=0x00, B=0x01, Bin=0 -> diff=0xFF, Bout=1, ovf=0.
- Signed overflow: A=0x80, B=0x01 -> diff=0x7F, Bout=0, ovf=1. Then A=0x7F, B=0xFF -> diff=0x80, Bout=1, ovf=1.
- Borrow-in: A=0x10, B=0x10, Bin=1 -> diff=0xFF, Bout=1, ovf=0. Same operands with Bin=0 -> diff=0x00, Bout=0.
- Busy protection: start with A=0x05, B=0x03; at cycle 3 pulse start with A=0xAA, B=0x11 -> second start ignored; diff=0x02; exactly one done pulse.
- Reset mid-op: start A=0x50, B=0x20, then assert rst at cycle 4 -> next cycle ready=1, diff=0x00, no done pulse. Then a new start A=0x09, B=0x04 -> diff=0x05 after the full latency.
